// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the fetch port, load/store port and single-port
//               memory signals that surround the mem_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int N = 32
);
    // fetch port
    logic           i_req;
    logic [N-1:0]   i_adr;
    logic           i_ack;
    logic [N-1:0]   i_rdata;
    // load/store port
    logic           d_req;
    logic [1:0]     d_we;
    logic [N-1:0]   d_adr;
    logic [N-1:0]   d_wdata;
    logic           d_ack;
    logic [N-1:0]   d_rdata;
    logic           d_err;
    // memory side
    logic [1:0]     memwrite;
    logic [N-1:0]   dataadr;
    logic [N-1:0]   writedata;
    logic [N-1:0]   readdata;
    // status
    logic           busy;

    // arbiter side
    modport slave (
        input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, readdata,
        output i_ack, i_rdata, d_ack, d_rdata, d_err,
               memwrite, dataadr, writedata, busy
    );

    // requesters and memory side
    modport master (
        output i_req, i_adr, d_req, d_we, d_adr, d_wdata, readdata,
        input  i_ack, i_rdata, d_ack, d_rdata, d_err,
               memwrite, dataadr, writedata, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port data memory between the instruction
//               fetch port and the load/store port. Each transaction takes
//               IDLE -> ACCESS -> RESP (3 cycles). Contention is resolved by
//               anti-starvation counters, then fixed data priority or
//               round-robin. Misaligned stores are suppressed and flagged.
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int N       = 32,
    parameter int DPRIO   = 0,
    parameter int MAXWAIT = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [3:0] C_MAXWAIT = 4'(MAXWAIT);
    localparam logic [3:0] C_WAITSAT = 4'hF;

    localparam logic P_FETCH = 1'b0;
    localparam logic P_DATA  = 1'b1;

    logic [1:0]   state_q, state_d;
    logic         owner_q;            // port owning the current transaction
    logic         rr_q;               // port that wins the next plain tie
    logic [3:0]   iwait_q, dwait_q;   // lost arbitrations per port
    logic [N-1:0] adr_q;
    logic [1:0]   we_q;
    logic [N-1:0] wdata_q;
    logic         misalign_q;
    logic [N-1:0] i_rdata_q, d_rdata_q;

    logic         w_any_req;
    logic         w_both_req;
    logic         w_grant;
    logic         w_misalign;

    assign w_any_req  = bus.i_req | bus.d_req;
    assign w_both_req = bus.i_req & bus.d_req;

    // Word stores need a word-aligned address, half stores a half-aligned one.
    assign w_misalign = ((bus.d_we == 2'd1) && (bus.d_adr[1:0] != 2'b00)) ||
                        ((bus.d_we == 2'd3) && bus.d_adr[0]);

    // Pick the port to grant: starving port first (fetch on a double stall),
    // then fixed data priority or the round-robin pointer.
    always_comb begin
        w_grant = P_FETCH;
        if (w_both_req) begin
            if (iwait_q == C_MAXWAIT)
                w_grant = P_FETCH;
            else if (dwait_q == C_MAXWAIT)
                w_grant = P_DATA;
            else if (DPRIO != 0)
                w_grant = P_DATA;
            else
                w_grant = rr_q;
        end else begin
            w_grant = bus.d_req ? P_DATA : P_FETCH;
        end
    end

    // State register; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Fixed three-step sequence once a request is seen in IDLE.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = w_any_req ? S_ACCESS : S_IDLE;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Memory strobe during ACCESS, owner's ack/err during RESP.
    always_comb begin
        bus.memwrite = 2'd0;
        bus.i_ack    = 1'b0;
        bus.d_ack    = 1'b0;
        bus.d_err    = 1'b0;
        bus.busy     = (state_q != S_IDLE);
        case (state_q)
            S_ACCESS: begin
                if ((owner_q == P_DATA) && !misalign_q)
                    bus.memwrite = we_q;
            end
            S_RESP: begin
                if (owner_q == P_DATA) begin
                    bus.d_ack = 1'b1;
                    bus.d_err = misalign_q;
                end else begin
                    bus.i_ack = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Grant bookkeeping in IDLE and read-data capture at the end of ACCESS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= P_FETCH;
            rr_q       <= P_FETCH;
            iwait_q    <= 4'd0;
            dwait_q    <= 4'd0;
            adr_q      <= '0;
            we_q       <= 2'd0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_any_req) begin
                        owner_q <= w_grant;
                        rr_q    <= ~w_grant;
                        if (w_grant == P_DATA) begin
                            adr_q      <= bus.d_adr;
                            we_q       <= bus.d_we;
                            wdata_q    <= bus.d_wdata;
                            misalign_q <= w_misalign;
                            dwait_q    <= 4'd0;
                            if (w_both_req)
                                iwait_q <= (iwait_q == C_WAITSAT) ? iwait_q : iwait_q + 4'd1;
                        end else begin
                            adr_q      <= bus.i_adr;
                            we_q       <= 2'd0;
                            wdata_q    <= '0;
                            misalign_q <= 1'b0;
                            iwait_q    <= 4'd0;
                            if (w_both_req)
                                dwait_q <= (dwait_q == C_WAITSAT) ? dwait_q : dwait_q + 4'd1;
                        end
                    end
                end
                S_ACCESS: begin
                    // Stores capture too, giving the pre-write word.
                    if (owner_q == P_DATA)
                        d_rdata_q <= bus.readdata;
                    else
                        i_rdata_q <= bus.readdata;
                end
                default: ;
            endcase
        end
    end

    assign bus.dataadr   = adr_q;
    assign bus.writedata = wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule
`default_nettype wire
